ura_hazard_scoreboard: RTL and testbench
========================================

// Module: ura_hazard_scoreboard
// PURPOSE
//  Tracks in-flight destination URAs (Unified Register Addresses, 7-bit) for the E/M/W stages.
//  Consumes the real destination URA produced by the D-stage destination decoder.
//  Compares the D-stage source URAs against the in-flight entries every cycle.
//  Produces the D-stage stall request and per-source forwarding selects for the datapath.
// PARAMETERS
//  URA_W   7  width of a unified register address
//  TIME_W  2  width of Tnew/Tuse counters (max value 3)
// PORTS
//  clk          in   1       clock
//  reset        in   1       synchronous, active-high reset
//  flush        in   1       exception/eret flush; invalidates all in-flight entries
//  d_valid      in   1       D-stage slot holds a real instruction (0 = bubble)
//  d_ura_dst    in   URA_W   D-stage real destination URA; 0 = no write
//  d_tnew       in   TIME_W  cycles after entering E until the result is forwardable
//  d_ura_src1   in   URA_W   D-stage source URA 1
//  d_tuse1      in   TIME_W  cycles after D until source 1 is consumed
//  d_ura_src2   in   URA_W   D-stage source URA 2
//  d_tuse2      in   TIME_W  cycles after D until source 2 is consumed
//  stall        out  1       hold PC/D register; E receives a bubble
//  fwd_sel1     out  2       source 1 forwarding: 0 none, 1 from E, 2 from M, 3 from W
//  fwd_sel2     out  2       source 2 forwarding, same encoding
//  e_ura        out  URA_W   destination URA held in E (0 if invalid)
//  m_ura        out  URA_W   destination URA held in M (0 if invalid)
//  w_ura        out  URA_W   destination URA held in W (0 if invalid)
// BEHAVIOUR
//  - Three registered entries E, M, W; each holds {valid, ura, tnew}.
//  - Reset: all entries valid=0, ura=0, tnew=0. Resulting outputs: stall=0, fwd_sel*=0, *_ura=0.
//  - Per-clock update, first matching rule wins:
//    - reset, or flush: all entries cleared, identical to reset. Flush takes priority over stall.
//    - otherwise: W<=M, M<=E, each with tnew decremented, saturating at 0.
//    - E <= {d_valid & ~stall & (d_ura_dst!=0), d_ura_dst, d_tnew}.
//    - When stall=1, E receives a bubble (valid=0, ura=0, tnew=0).
//  - The D-stage destination never appears as an in-flight source: it is not compared in the same cycle.
//  - Match: for source s, entry X matches iff X.valid & X.ura==d_ura_src_s & d_ura_src_s!=0.
//    - URA 0 never matches.
//    - HI/LO (7'h40/7'h41) and CP0 (7'h20-3F) match like any other URA.
//  - Only the youngest match counts (priority E > M > W); older matches are shadowed.
//  - Stall (combinational, from current state and D inputs):
//    - stall = d_valid & OR over s of (youngest match exists & its tnew > d_tuse_s).
//  - Forwarding (combinational):
//    - fwd_sel_s = stage code of the youngest match when its tnew==0; else 0.
//    - If the youngest match has tnew!=0, fwd_sel_s=0 even when an older stage matches.
//    - The stall covers that case.
//  - Latency: stall and fwd_sel* follow the inputs within the same cycle.
//    - Entry movement takes effect at the next clock edge.
//  - Reset or flush mid-stall: stall drops in the cycle after the edge unless D inputs re-trigger it.
// TESTING
//  - Reset: assert reset 1 cycle. Expect stall=0, fwd_sel1=fwd_sel2=0, e/m/w_ura=0.
//  - lw-use:
//    - D: dst=8, tnew=2. Next cycle D: src1=8, tuse1=0.
//    - Expect stall=1 for 2 cycles.
//    - Then fwd_sel1=3 (W) and stall=0, with a bubble in E each stalled cycle.
//  - ALU back-to-back:
//    - D: dst=9, tnew=1. Next cycle D: src2=9, tuse2=1.
//    - Expect stall=0, fwd_sel2=0. Next cycle fwd_sel2=2 (M).
//  - Shadowing:
//    - E: ura=5, tnew=1. M: ura=5, tnew=0. D: src1=5, tuse1=0.
//    - Expect stall=1, fwd_sel1=0; never 2.
//  - Zero/HI:
//    - E: dst=0 from an instruction with d_tnew=0. D: src1=0. Expect no match, fwd_sel1=0.
//    - E: dst=7'h40, tnew=0. D: src2=7'h40. Expect fwd_sel2=1.
//  - Flush:
//    - Assert flush while stall=1 (E: ura=8, tnew=2).
//    - Next cycle: e/m/w_ura=0, stall=0, fwd_sel*=0.

Source files
------------

// File: rtl/ura_hazard_scoreboard.sv
// Tracks in-flight destination URAs in E/M/W and resolves D-stage source
// hazards into a stall request and per-source forwarding selects.
module ura_hazard_scoreboard #(
   parameter int unsigned URA_W  = 7,
   parameter int unsigned TIME_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              d_valid,
   input  logic [URA_W-1:0]  d_ura_dst,
   input  logic [TIME_W-1:0] d_tnew,
   input  logic [URA_W-1:0]  d_ura_src1,
   input  logic [TIME_W-1:0] d_tuse1,
   input  logic [URA_W-1:0]  d_ura_src2,
   input  logic [TIME_W-1:0] d_tuse2,
   output logic              stall,
   output logic [1:0]        fwd_sel1,
   output logic [1:0]        fwd_sel2,
   output logic [URA_W-1:0]  e_ura,
   output logic [URA_W-1:0]  m_ura,
   output logic [URA_W-1:0]  w_ura
);

   localparam int unsigned N_STG = 3;

   // index 0 = E, 1 = M, 2 = W
   logic              r_valid [N_STG];
   logic [URA_W-1:0]  r_ura   [N_STG];
   logic [TIME_W-1:0] r_tnew  [N_STG];

   logic [N_STG-1:0]  w_hit1;
   logic [N_STG-1:0]  w_hit2;
   logic              w_haz1;
   logic              w_haz2;
   logic [1:0]        w_sel1;
   logic [1:0]        w_sel2;
   logic              w_stall;

   // source match against every valid in-flight entry; URA 0 never matches
   always_comb begin
      w_hit1 = '0;
      w_hit2 = '0;
      for (int i = 0; i < N_STG; i++) begin
         w_hit1[i] = r_valid[i] && (r_ura[i] == d_ura_src1) && (d_ura_src1 != '0);
         w_hit2[i] = r_valid[i] && (r_ura[i] == d_ura_src2) && (d_ura_src2 != '0);
      end
   end

   // walk oldest to youngest so the youngest match overrides (shadowing)
   always_comb begin
      w_haz1 = 1'b0;
      w_haz2 = 1'b0;
      w_sel1 = 2'd0;
      w_sel2 = 2'd0;
      for (int i = N_STG - 1; i >= 0; i--) begin
         if (w_hit1[i]) begin
            w_haz1 = (r_tnew[i] > d_tuse1);
            w_sel1 = (r_tnew[i] == '0) ? 2'(i + 1) : 2'd0;
         end
         if (w_hit2[i]) begin
            w_haz2 = (r_tnew[i] > d_tuse2);
            w_sel2 = (r_tnew[i] == '0) ? 2'(i + 1) : 2'd0;
         end
      end
      w_stall = d_valid && (w_haz1 || w_haz2);
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         for (int i = 0; i < N_STG; i++) begin
            r_valid[i] <= 1'b0;
            r_ura[i]   <= '0;
            r_tnew[i]  <= '0;
         end
      end else begin
         for (int i = 1; i < N_STG; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_ura[i]   <= r_ura[i-1];
            r_tnew[i]  <= (r_tnew[i-1] == '0) ? '0 : r_tnew[i-1] - TIME_W'(1);
         end
         // a stalled D slot enters E as a bubble
         if (w_stall) begin
            r_valid[0] <= 1'b0;
            r_ura[0]   <= '0;
            r_tnew[0]  <= '0;
         end else begin
            r_valid[0] <= d_valid && (d_ura_dst != '0);
            r_ura[0]   <= d_ura_dst;
            r_tnew[0]  <= d_tnew;
         end
      end
   end

   assign stall    = w_stall;
   assign fwd_sel1 = w_sel1;
   assign fwd_sel2 = w_sel2;
   assign e_ura    = r_valid[0] ? r_ura[0] : '0;
   assign m_ura    = r_valid[1] ? r_ura[1] : '0;
   assign w_ura    = r_valid[2] ? r_ura[2] : '0;

endmodule

// File: tb/tb_ura_hazard_scoreboard.sv
// Directed vector bench for ura_hazard_scoreboard: table of D-stage inputs
// with hand-computed outputs, plus flush/reset-during-stall sequences.
module tb_ura_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       reset, flush, d_valid;
   logic [6:0] d_ura_dst, d_ura_src1, d_ura_src2;
   logic [1:0] d_tnew, d_tuse1, d_tuse2;
   logic       stall;
   logic [1:0] fwd_sel1, fwd_sel2;
   logic [6:0] e_ura, m_ura, w_ura;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ura_hazard_scoreboard dut (
      .clk(clk), .reset(reset), .flush(flush), .d_valid(d_valid),
      .d_ura_dst(d_ura_dst), .d_tnew(d_tnew),
      .d_ura_src1(d_ura_src1), .d_tuse1(d_tuse1),
      .d_ura_src2(d_ura_src2), .d_tuse2(d_tuse2),
      .stall(stall), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
      .e_ura(e_ura), .m_ura(m_ura), .w_ura(w_ura)
   );

   typedef struct {
      logic       rst, fl, dv;
      logic [6:0] dst;
      logic [1:0] tn;
      logic [6:0] s1;
      logic [1:0] u1;
      logic [6:0] s2;
      logic [1:0] u2;
      logic       x_st;
      logic [1:0] x_f1, x_f2;
      logic [6:0] x_e, x_m, x_w;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(int rst, int fl, int dv, int dst, int tn, int s1, int u1,
                               int s2, int u2, int st, int f1, int f2, int e, int m, int w);
      vec_t v;
      v.rst = 1'(rst); v.fl = 1'(fl); v.dv = 1'(dv);
      v.dst = 7'(dst); v.tn = 2'(tn);
      v.s1 = 7'(s1); v.u1 = 2'(u1); v.s2 = 7'(s2); v.u2 = 2'(u2);
      v.x_st = 1'(st); v.x_f1 = 2'(f1); v.x_f2 = 2'(f2);
      v.x_e = 7'(e); v.x_m = 7'(m); v.x_w = 7'(w);
      return v;
   endfunction

   task automatic drive(input vec_t v);
      reset = v.rst; flush = v.fl; d_valid = v.dv;
      d_ura_dst = v.dst; d_tnew = v.tn;
      d_ura_src1 = v.s1; d_tuse1 = v.u1;
      d_ura_src2 = v.s2; d_tuse2 = v.u2;
   endtask

   task automatic check(input string name, input vec_t v);
      n_vec++;
      if (stall !== v.x_st || fwd_sel1 !== v.x_f1 || fwd_sel2 !== v.x_f2 ||
          e_ura !== v.x_e || m_ura !== v.x_m || w_ura !== v.x_w) begin
         n_err++;
         $display("FAIL %s: got st=%0b f1=%0d f2=%0d e=%h m=%h w=%h, want st=%0b f1=%0d f2=%0d e=%h m=%h w=%h",
                  name, stall, fwd_sel1, fwd_sel2, e_ura, m_ura, w_ura,
                  v.x_st, v.x_f1, v.x_f2, v.x_e, v.x_m, v.x_w);
      end
   endtask

   // apply at negedge, sample 1ns later: state reflects all previous edges
   task automatic step(input string name, input vec_t v);
      @(negedge clk);
      drive(v);
      #1;
      check(name, v);
   endtask

   initial begin
      //            rst fl dv dst  tn s1   u1 s2   u2 | st f1 f2 e     m     w
      tbl.push_back(mk(1, 0, 0, 0,    0, 0,    0, 0,    0,  0, 0, 0, 0,    0,    0));    // 0 reset
      tbl.push_back(mk(0, 0, 1, 8,    2, 0,    0, 0,    0,  0, 0, 0, 0,    0,    0));    // 1 lw
      tbl.push_back(mk(0, 0, 1, 0,    0, 8,    0, 0,    0,  1, 0, 0, 8,    0,    0));    // 2 use: stall
      tbl.push_back(mk(0, 0, 1, 0,    0, 8,    0, 0,    0,  1, 0, 0, 0,    8,    0));    // 3 stall
      tbl.push_back(mk(0, 0, 1, 0,    0, 8,    0, 0,    0,  0, 3, 0, 0,    0,    8));    // 4 fwd W
      tbl.push_back(mk(0, 0, 1, 9,    1, 0,    0, 0,    0,  0, 0, 0, 0,    0,    0));    // 5 alu
      tbl.push_back(mk(0, 0, 1, 0,    0, 0,    0, 9,    1,  0, 0, 0, 9,    0,    0));    // 6 tnew==tuse
      tbl.push_back(mk(0, 0, 1, 0,    0, 0,    0, 9,    1,  0, 0, 2, 0,    9,    0));    // 7 fwd M
      tbl.push_back(mk(0, 0, 1, 5,    1, 0,    0, 0,    0,  0, 0, 0, 0,    0,    9));    // 8
      tbl.push_back(mk(0, 0, 1, 5,    1, 0,    0, 0,    0,  0, 0, 0, 5,    0,    0));    // 9
      tbl.push_back(mk(0, 0, 1, 0,    0, 5,    0, 0,    0,  1, 0, 0, 5,    5,    0));    // 10 shadow
      tbl.push_back(mk(0, 0, 1, 0,    0, 0,    0, 5,    0,  0, 0, 2, 0,    5,    5));    // 11 zero src
      tbl.push_back(mk(0, 0, 1, 'h40, 0, 0,    0, 5,    0,  0, 0, 3, 0,    0,    5));    // 12 W sat tnew
      tbl.push_back(mk(0, 0, 1, 0,    0, 5,    0, 'h40, 0,  0, 0, 1, 'h40, 0,    0));    // 13 HI from E
      tbl.push_back(mk(0, 0, 1, 'h21, 1, 0,    0, 'h40, 0,  0, 0, 2, 0,    'h40, 0));    // 14 HI from M
      tbl.push_back(mk(0, 0, 1, 0,    0, 'h21, 0, 0,    0,  1, 0, 0, 'h21, 0,    'h40)); // 15 CP0 stall
      tbl.push_back(mk(0, 0, 0, 'h30, 0, 'h21, 0, 0,    0,  0, 2, 0, 0,    'h21, 0));    // 16 no dv
      tbl.push_back(mk(0, 0, 0, 0,    0, 'h30, 0, 0,    0,  0, 0, 0, 0,    0,    'h21)); // 17 dv=0 dst
      tbl.push_back(mk(0, 0, 1, 12,   3, 0,    0, 0,    0,  0, 0, 0, 0,    0,    0));    // 18 tnew 3
      tbl.push_back(mk(0, 0, 1, 0,    0, 0,    0, 0,    0,  0, 0, 0, 12,   0,    0));    // 19
      tbl.push_back(mk(0, 0, 1, 0,    0, 12,   0, 0,    0,  1, 0, 0, 0,    12,   0));    // 20
      tbl.push_back(mk(0, 0, 1, 0,    0, 12,   0, 0,    0,  1, 0, 0, 0,    0,    12));   // 21

      drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);

      foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

      // flush while stalled, with a live D destination that must not enter E
      step("pre_rst",   mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
      step("fl_load",   mk(0, 0, 1, 8, 2, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
      step("fl_stall",  mk(0, 1, 1, 7, 1, 8, 0, 0, 0,  1, 0, 0, 8, 0, 0));
      step("fl_after",  mk(0, 0, 1, 0, 0, 8, 0, 8, 0,  0, 0, 0, 0, 0, 0));

      // reset while stalled
      step("rs_load",   mk(0, 0, 1, 8, 2, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
      step("rs_stall",  mk(1, 0, 1, 0, 0, 0, 0, 8, 1,  1, 0, 0, 8, 0, 0));
      step("rs_after",  mk(0, 0, 1, 0, 0, 0, 0, 8, 1,  0, 0, 0, 0, 0, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
